mul_unit: RTL

- Iterative multiply/multiply-accumulate execution unit for ARM MUL/MLA, placed directly downstream of the register-file read ports.
- Consumes the Rm, Rs and Rn operand reads, computes Rd = Rm*Rs (+Rn) with a radix-2 shift-add datapath over multiple cycles, and returns a one-cycle write-back request (data, address, enable) plus N/Z flag updates.
- The control unit stalls the PC while busy is high.

---
 rtl/mul_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiply / multiply-accumulate unit (ARM MUL/MLA).
// Latches operands on start and performs one shift-add step per cycle.
// Returns a one-cycle write-back request plus N/Z flag updates.
module mul_unit #(
    parameter int EARLY_TERM = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        accumulate,
    input  logic        set_flags,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] op_acc,
    input  logic [3:0]  dest,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  result_waddr,
    output logic        result_we,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flags_we
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg;
    logic [31:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [31:0] product_reg;
    logic [31:0] acc_reg;
    logic [5:0]  cnt_reg;
    logic        acc_en_reg;
    logic        sf_reg;
    logic [3:0]  dest_reg;
    logic [31:0] result_reg;
    logic [3:0]  waddr_reg;
    logic        flag_n_reg;
    logic        flag_z_reg;

    logic        mul_last;
    logic [31:0] final_sum;

    // Iteration ends after 32 steps, or early once no multiplier bits remain
    always_comb begin
        mul_last = (cnt_reg == 6'd32) || ((EARLY_TERM != 0) && (mplier_reg == 32'd0));
    end

    // Final value written back: product, optionally plus the accumulate operand
    always_comb begin
        final_sum = acc_en_reg ? (product_reg + acc_reg) : product_reg;
    end

    // Control FSM, datapath and registered write-back outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            mcand_reg   <= 32'd0;
            mplier_reg  <= 32'd0;
            product_reg <= 32'd0;
            acc_reg     <= 32'd0;
            cnt_reg     <= 6'd0;
            acc_en_reg  <= 1'b0;
            sf_reg      <= 1'b0;
            dest_reg    <= 4'd0;
            result_reg  <= 32'd0;
            waddr_reg   <= 4'd0;
            flag_n_reg  <= 1'b0;
            flag_z_reg  <= 1'b1;
        end else if (flush) begin
            // Abort discards the operation; visible results are left untouched
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg   <= op_a;
                        mplier_reg  <= op_b;
                        acc_reg     <= op_acc;
                        acc_en_reg  <= accumulate;
                        sf_reg      <= set_flags;
                        dest_reg    <= dest;
                        product_reg <= 32'd0;
                        cnt_reg     <= 6'd0;
                        state_reg   <= MUL;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        state_reg <= ACC;
                    end else begin
                        if (mplier_reg[0]) begin
                            product_reg <= product_reg + mcand_reg;
                        end
                        mcand_reg  <= {mcand_reg[30:0], 1'b0};
                        mplier_reg <= {1'b0, mplier_reg[31:1]};
                        cnt_reg    <= cnt_reg + 6'd1;
                    end
                end
                ACC: begin
                    product_reg <= final_sum;
                    result_reg  <= final_sum;
                    waddr_reg   <= dest_reg;
                    flag_n_reg  <= final_sum[31];
                    flag_z_reg  <= (final_sum == 32'd0);
                    state_reg   <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign result_we    = done;
    assign flags_we     = done & sf_reg;
    assign result       = result_reg;
    assign result_waddr = waddr_reg;
    assign flag_n       = flag_n_reg;
    assign flag_z       = flag_z_reg;

endmodule
